count7_pwm_ext: RTL and testbench

- Control/consumer stage directly downstream of the 7-bit down-counter primitive (cy_psoc3_count7, period 127, routed enable and load).
- Consumes the counter's count value and terminal count. Drives the counter's enable and load.
- Produces a registered PWM from a compare value and extends the 7-bit period with a programmable EXT_WIDTH-bit tc prescaler.
- Provides a sticky interrupt with overflow detection and an optional one-shot mode.

---
 rtl/count7_pwm_ext_pkg.sv | 21 ++
 rtl/count7_pwm_ext_shadow.sv | 48 ++++
 rtl/count7_pwm_ext.sv | 140 ++++++++++++++
 tb/tb_count7_pwm_ext.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/count7_pwm_ext_pkg.sv
// Shared types and constants for the count7 PWM / prescaler stage.
// Imported by the top and by the bench.
package count7_pwm_ext_pkg;

  localparam int unsigned CNT7_WIDTH = 7;
  localparam logic [CNT7_WIDTH-1:0] CNT7_PERIOD = 7'd127;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic pwm_on(
    input logic [CNT7_WIDTH-1:0] cnt,
    input logic [CNT7_WIDTH-1:0] cmp
  );
    return cnt < cmp;
  endfunction

endpackage

// File: rtl/count7_pwm_ext_shadow.sv
// Shadow/active register pair: writes go live at once when idle,
// otherwise at the next transfer; a write on a transfer wins.
module count7_pwm_ext_shadow #(
  parameter int unsigned    W    = 7,
  parameter logic [W-1:0]   INIT = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_i,
  input  logic [W-1:0] data_i,
  input  logic         idle_i,
  input  logic         xfer_i,
  output logic [W-1:0] active_o,
  output logic [W-1:0] next_o
);

  logic [W-1:0] shadow_q;
  logic [W-1:0] shadow_d;
  logic [W-1:0] active_q;
  logic [W-1:0] active_d;

  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    if (wr_i) begin
      shadow_d = data_i;
    end
    if (wr_i && (idle_i || xfer_i)) begin
      active_d = data_i;
    end else if (xfer_i) begin
      active_d = shadow_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= INIT;
      active_q <= INIT;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end

  assign active_o = active_q;
  assign next_o   = wr_i ? data_i : shadow_q;

endmodule

// File: rtl/count7_pwm_ext.sv
// Control stage behind the 7-bit down counter: start/stop FSM,
// registered PWM, extended tc prescaler and sticky irq/ovf.
module count7_pwm_ext
  import count7_pwm_ext_pkg::*;
#(
  parameter int unsigned           EXT_WIDTH = 8,
  parameter logic [CNT7_WIDTH-1:0] CMP_INIT  = 7'd64,
  parameter logic [EXT_WIDTH-1:0]  PER_INIT  = '0,
  parameter logic                  ONE_SHOT  = 1'b0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  stop,
  input  logic [CNT7_WIDTH-1:0] cnt_in,
  input  logic                  tc_in,
  output logic                  cnt_en,
  output logic                  cnt_load,
  input  logic                  cmp_wr,
  input  logic [CNT7_WIDTH-1:0] cmp_data,
  input  logic                  per_wr,
  input  logic [EXT_WIDTH-1:0]  per_data,
  input  logic                  irq_clr,
  output logic                  pwm,
  output logic                  ext_tc,
  output logic [EXT_WIDTH-1:0]  ext_cnt,
  output logic                  irq,
  output logic                  ovf,
  output logic                  busy
);

  state_e                  state_q;
  logic                    load_q;
  logic                    pwm_q;
  logic                    ext_tc_q;
  logic [EXT_WIDTH-1:0]    ext_cnt_q;
  logic                    irq_q;
  logic                    ovf_q;

  logic                    run;
  logic                    go;
  logic                    tc_hit;
  logic                    wrap;
  logic [CNT7_WIDTH-1:0]   cmp_active;
  logic [CNT7_WIDTH-1:0]   cmp_next_unused;
  logic [EXT_WIDTH-1:0]    per_active;
  logic [EXT_WIDTH-1:0]    per_next;

  assign run    = (state_q == ST_RUN);
  assign go     = !run && start;
  assign tc_hit = run && tc_in && !stop;
  assign wrap   = tc_hit && (ext_cnt_q == '0);

  count7_pwm_ext_shadow #(
    .W    (CNT7_WIDTH),
    .INIT (CMP_INIT)
  ) u_cmp (
    .clk      (clock),
    .rst_n    (reset),
    .wr_i     (cmp_wr),
    .data_i   (cmp_data),
    .idle_i   (!run),
    .xfer_i   (wrap),
    .active_o (cmp_active),
    .next_o   (cmp_next_unused)
  );

  count7_pwm_ext_shadow #(
    .W    (EXT_WIDTH),
    .INIT (PER_INIT)
  ) u_per (
    .clk      (clock),
    .rst_n    (reset),
    .wr_i     (per_wr),
    .data_i   (per_data),
    .idle_i   (!run),
    .xfer_i   (wrap),
    .active_o (per_active),
    .next_o   (per_next)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      load_q    <= 1'b0;
      pwm_q     <= 1'b0;
      ext_tc_q  <= 1'b0;
      ext_cnt_q <= '0;
      irq_q     <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      load_q   <= go;
      ext_tc_q <= wrap;
      pwm_q    <= run && pwm_on(cnt_in, cmp_active);
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_q   <= ST_RUN;
            ext_cnt_q <= per_active;
          end
        end
        ST_RUN: begin
          if (stop) begin
            state_q <= ST_IDLE;
          end else if (tc_in) begin
            if (ext_cnt_q == '0) begin
              ext_cnt_q <= per_next;
              if (ONE_SHOT) begin
                state_q <= ST_DONE;
              end
            end else begin
              ext_cnt_q <= ext_cnt_q - EXT_WIDTH'(1);
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
      // a wrap pulse beats a same-cycle clear; ovf then holds
      if (ext_tc_q) begin
        irq_q <= 1'b1;
        if (irq_q && !irq_clr) begin
          ovf_q <= 1'b1;
        end
      end else if (irq_clr) begin
        irq_q <= 1'b0;
        ovf_q <= 1'b0;
      end
    end
  end

  assign cnt_en   = run;
  assign busy     = run;
  assign cnt_load = load_q;
  assign pwm      = pwm_q;
  assign ext_tc   = ext_tc_q;
  assign ext_cnt  = ext_cnt_q;
  assign irq      = irq_q;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_count7_pwm_ext.sv
// Directed bench for count7_pwm_ext with a behavioural model,
// a counter model and an expected-output queue.
module tb_count7_pwm_ext;
  import count7_pwm_ext_pkg::*;

  typedef struct packed {
    logic       pwm;
    logic       ext_tc;
    logic       ld;
    logic       busy;
    logic       irq;
    logic       ovf;
    logic [7:0] ext_cnt;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [6:0] cnt_in = 7'd127;
  logic       tc_in = 1'b0;
  logic       cmp_wr = 1'b0;
  logic [6:0] cmp_data = '0;
  logic       per_wr = 1'b0;
  logic [7:0] per_data = '0;
  logic       irq_clr = 1'b0;

  logic       cnt_en_0, cnt_load_0, pwm_0, ext_tc_0;
  logic       irq_0, ovf_0, busy_0;
  logic [7:0] ext_cnt_0;
  logic       cnt_en_1, cnt_load_1, pwm_1, ext_tc_1;
  logic       irq_1, ovf_1, busy_1;
  logic [7:0] ext_cnt_1;

  int checks = 0;
  int errors = 0;

  logic       sel;
  logic       os_m;
  logic       run_m, ld_m, ext_tc_m, irq_m, ovf_m;
  logic [7:0] ext_m, per_act_m, per_sh_m;
  logic [6:0] cmp_act_m, cmp_sh_m, cnt_m;
  exp_t       q[$];

  always #5 clock = ~clock;

  count7_pwm_ext u0 (
    .clock(clock), .reset(reset), .start(start), .stop(stop),
    .cnt_in(cnt_in), .tc_in(tc_in),
    .cnt_en(cnt_en_0), .cnt_load(cnt_load_0),
    .cmp_wr(cmp_wr), .cmp_data(cmp_data),
    .per_wr(per_wr), .per_data(per_data), .irq_clr(irq_clr),
    .pwm(pwm_0), .ext_tc(ext_tc_0), .ext_cnt(ext_cnt_0),
    .irq(irq_0), .ovf(ovf_0), .busy(busy_0)
  );

  count7_pwm_ext #(.ONE_SHOT(1'b1)) u1 (
    .clock(clock), .reset(reset), .start(start), .stop(stop),
    .cnt_in(cnt_in), .tc_in(tc_in),
    .cnt_en(cnt_en_1), .cnt_load(cnt_load_1),
    .cmp_wr(cmp_wr), .cmp_data(cmp_data),
    .per_wr(per_wr), .per_data(per_data), .irq_clr(irq_clr),
    .pwm(pwm_1), .ext_tc(ext_tc_1), .ext_cnt(ext_cnt_1),
    .irq(irq_1), .ovf(ovf_1), .busy(busy_1)
  );

  task automatic chk(input string tag,
                     input logic [31:0] o,
                     input logic [31:0] x);
    checks++;
    assert (o === x) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, x);
    end
  endtask

  function automatic exp_t obs();
    exp_t o;
    if (sel) begin
      o = '{pwm_1, ext_tc_1, cnt_load_1, busy_1,
            irq_1, ovf_1, ext_cnt_1};
    end else begin
      o = '{pwm_0, ext_tc_0, cnt_load_0, busy_0,
            irq_0, ovf_0, ext_cnt_0};
    end
    return o;
  endfunction

  function automatic logic cen();
    return sel ? cnt_en_1 : cnt_en_0;
  endfunction

  task automatic model_rst();
    run_m = 0; ld_m = 0; ext_tc_m = 0;
    irq_m = 0; ovf_m = 0; ext_m = '0;
    cmp_act_m = 7'd64; cmp_sh_m = 7'd64;
    per_act_m = '0; per_sh_m = '0;
    cnt_m = 7'd127;
  endtask

  task automatic cyc();
    exp_t e, g;
    logic wrap, run_n;
    logic [7:0] ext_n, pa_n, ps_n;
    logic [6:0] ca_n, cs_n;
    e = '0;
    run_n = run_m; ext_n = ext_m;
    pa_n = per_act_m; ps_n = per_sh_m;
    ca_n = cmp_act_m; cs_n = cmp_sh_m;
    if (reset) begin
      wrap = run_m && !stop && tc_in && ext_m == 0;
      e.pwm = run_m && (cnt_in < cmp_act_m);
      e.ext_tc = wrap;
      e.ld = !run_m && start;
      if (!run_m) begin
        if (start) begin
          run_n = 1; ext_n = per_act_m;
        end
      end else if (stop) begin
        run_n = 0;
      end else if (tc_in) begin
        if (ext_m == 0) begin
          ext_n = per_wr ? per_data : per_sh_m;
          if (os_m) run_n = 0;
        end else begin
          ext_n = ext_m - 8'd1;
        end
      end
      if (cmp_wr) begin
        cs_n = cmp_data;
        if (!run_m || wrap) ca_n = cmp_data;
      end else if (wrap) ca_n = cmp_sh_m;
      if (per_wr) begin
        ps_n = per_data;
        if (!run_m || wrap) pa_n = per_data;
      end else if (wrap) pa_n = per_sh_m;
      e.irq = ext_tc_m ? 1'b1 : (irq_clr ? 1'b0 : irq_m);
      if (ext_tc_m && irq_clr) e.ovf = ovf_m;
      else if (ext_tc_m && irq_m) e.ovf = 1'b1;
      else if (irq_clr) e.ovf = 1'b0;
      else e.ovf = ovf_m;
      e.busy = run_n;
      e.ext_cnt = ext_n;
    end
    q.push_back(e);
    @(posedge clock);
    #1;
    if (!reset) begin
      model_rst();
    end else begin
      if (ld_m) cnt_m = 7'd127;
      else if (run_m) cnt_m = cnt_m - 7'd1;
      run_m = run_n; ext_m = ext_n;
      per_act_m = pa_n; per_sh_m = ps_n;
      cmp_act_m = ca_n; cmp_sh_m = cs_n;
      ld_m = e.ld; ext_tc_m = e.ext_tc;
      irq_m = e.irq; ovf_m = e.ovf;
    end
    g = obs();
    e = q.pop_front();
    chk("pwm", g.pwm, e.pwm);
    chk("ext_tc", g.ext_tc, e.ext_tc);
    chk("cnt_load", g.ld, e.ld);
    chk("busy", g.busy, e.busy);
    chk("cnt_en", cen(), e.busy);
    chk("irq", g.irq, e.irq);
    chk("ovf", g.ovf, e.ovf);
    chk("ext_cnt", g.ext_cnt, e.ext_cnt);
    cnt_in = cnt_m;
    tc_in = (cnt_m == 0);
    start = 0; stop = 0; cmp_wr = 0;
    per_wr = 0; irq_clr = 0;
  endtask

  task automatic run_n_cyc(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic run_tc(input int n, output int pulses);
    int seen, guard;
    seen = 0; guard = 0; pulses = 0;
    while (seen < n && guard < n * 300 + 10) begin
      if (run_m && tc_in) seen++;
      cyc();
      if (obs().ext_tc) pulses++;
      guard++;
    end
    chk("tc_budget", seen, n);
  endtask

  task automatic count_pwm(input int n, output int hi);
    hi = 0;
    for (int i = 0; i < n; i++) begin
      cyc();
      if (obs().pwm) hi++;
    end
  endtask

  task automatic wait_wrap();
    int guard;
    guard = 0;
    while (!(run_m && tc_in && ext_m == 0) && guard < 1000) begin
      cyc();
      guard++;
    end
    chk("wrap_budget", guard < 1000, 1);
  endtask

  initial begin
    int p, hi, guard;
    sel = 0; os_m = 0;
    model_rst();
    run_n_cyc(2);
    reset = 1;
    cyc();

    // 1: reset mid-run
    start = 1; cyc();
    run_tc(3, p);
    chk("t1_pulses", p, 3);
    reset = 0;
    #1;
    chk("t1_cnt_en_async", cnt_en_0, 0);
    chk("t1_busy_async", busy_0, 0);
    chk("t1_irq_async", irq_0, 0);
    chk("t1_cmp_active", u0.cmp_active, 64);
    chk("t1_ext_cnt", ext_cnt_0, 0);
    run_n_cyc(2);
    reset = 1;
    cyc();
    chk("t1_cmp_after", u0.cmp_active, 64);

    // 2: PER=2 prescale
    per_wr = 1; per_data = 8'd2; cyc();
    start = 1; cyc();
    chk("t2_load", cnt_load_0, 1);
    chk("t2_cnt_en", cnt_en_0, 1);
    cyc();
    chk("t2_load_once", cnt_load_0, 0);
    run_tc(9, p);
    chk("t2_pulses", p, 3);
    run_n_cyc(2);
    chk("t2_irq", irq_0, 1);
    chk("t2_ovf", ovf_0, 1);
    stop = 1; cyc();

    // 3: duty 32 then 0
    cmp_wr = 1; cmp_data = 7'd32; cyc();
    start = 1; cyc();
    run_n_cyc(300);
    count_pwm(128, hi);
    chk("t3_duty32", hi, 32);
    stop = 1; cyc();
    cmp_wr = 1; cmp_data = 7'd0; cyc();
    start = 1; cyc();
    count_pwm(300, hi);
    chk("t3_duty0", hi, 0);
    stop = 1; cyc();

    // 4: deferred and coincident compare writes
    per_wr = 1; per_data = 8'd1; cyc();
    cmp_wr = 1; cmp_data = 7'd32; cyc();
    start = 1; cyc();
    run_n_cyc(200);
    cmp_wr = 1; cmp_data = 7'd100; cyc();
    chk("t4_held", u0.cmp_active, 32);
    wait_wrap();
    cyc();
    chk("t4_applied", u0.cmp_active, 100);
    count_pwm(128, hi);
    chk("t4_duty100", hi, 100);
    wait_wrap();
    cmp_wr = 1; cmp_data = 7'd20; cyc();
    chk("t4_write_wins", u0.cmp_active, 20);

    // 5: irq / ovf
    cyc();
    irq_clr = 1; cyc();
    chk("t5_clr_irq", irq_0, 0);
    chk("t5_clr_ovf", ovf_0, 0);
    run_tc(4, p);
    run_n_cyc(2);
    chk("t5_ovf_set", ovf_0, 1);
    chk("t5_irq_set", irq_0, 1);
    guard = 0;
    while (!ext_tc_m && guard < 1000) begin
      cyc(); guard++;
    end
    chk("t5_tc_budget", guard < 1000, 1);
    irq_clr = 1; cyc();
    chk("t5_set_wins", irq_0, 1);
    chk("t5_ovf_hold", ovf_0, 1);
    irq_clr = 1; cyc();
    chk("t5_lone_irq", irq_0, 0);
    chk("t5_lone_ovf", ovf_0, 0);

    // 6: one-shot instance
    stop = 1; cyc();
    reset = 0; cyc();
    reset = 1; sel = 1; os_m = 1; cyc();
    start = 1; cyc();
    run_tc(1, p);
    chk("t6_pulse", p, 1);
    chk("t6_done_busy", busy_1, 0);
    chk("t6_done_en", cnt_en_1, 0);
    run_n_cyc(3);
    chk("t6_stays_done", busy_1, 0);
    per_wr = 1; per_data = 8'd3; cyc();
    start = 1; cyc();
    chk("t6_ext_load", ext_cnt_1, 3);
    guard = 0;
    while (!(run_m && tc_in) && guard < 400) begin
      cyc(); guard++;
    end
    chk("t6_tc_budget", guard < 400, 1);
    stop = 1; cyc();
    chk("t6_stop_no_tc", ext_tc_1, 0);
    chk("t6_stop_idle", busy_1, 0);
    chk("t6_ext_hold", ext_cnt_1, 3);
    cyc();
    chk("t6_no_late_tc", ext_tc_1, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
